// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to 4-digit BCD converter with saturation and leading-zero mask
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-low reset
//   start_i conversion request, sampled only in IDLE
//   data_i  N-bit unsigned value, captured when start is accepted
//   bcd_o   packed result {thousands, hundreds, tens, units}
//   lead_o  leading-zero mask, bit i set when digit i is a leading zero
//   busy_o  high while a conversion is in progress
//   done_o  one-cycle pulse when the result outputs update
//   ovf_o   last converted value exceeded 9999
module bin_to_bcd_seq #(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] data_i,
  output logic [15:0]  bcd_o,
  output logic [3:0]   lead_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         ovf_o
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nxt;
  logic [N-1:0] sr;
  logic [19:0] acc, adj;
  logic [CW-1:0] cnt;
  logic [15:0] bcd_nxt;
  logic [3:0] lead_nxt;
  logic ovf_nxt;
  for (genvar g = 0; g < 5; g++) begin : g_adj
    assign adj[4*g +: 4] = acc[4*g +: 4] >= 4'd5 ? acc[4*g +: 4] + 4'd3 : acc[4*g +: 4];
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (start_i ? CONV : IDLE) :
                state == CONV ? (cnt == CW'(N - 1) ? DONE : CONV) : IDLE;
    // a nonzero fifth digit means the value exceeded 9999
    ovf_nxt = |acc[19:16];
    bcd_nxt = ovf_nxt ? 16'h9999 : acc[15:0];
    lead_nxt[3] = bcd_nxt[15:12] == 4'd0;
    lead_nxt[2] = lead_nxt[3] && bcd_nxt[11:8] == 4'd0;
    lead_nxt[1] = lead_nxt[2] && bcd_nxt[7:4] == 4'd0;
    lead_nxt[0] = 1'b0;
  end
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd_o  <= 16'h0000;
      lead_o <= 4'b1110;
      ovf_o  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= state == DONE;
      if (state == IDLE && start_i) begin
        sr  <= data_i;
        acc <= '0;
        cnt <= '0;
      end
      if (state == CONV) begin
        {acc, sr} <= {adj[18:0], sr, 1'b0};
        cnt       <= cnt + CW'(1);
      end
      if (state == DONE) begin
        bcd_o  <= bcd_nxt;
        lead_o <= lead_nxt;
        ovf_o  <= ovf_nxt;
      end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq (N=16 and N=8 instances)
module tb_bin_to_bcd_seq;
  logic clk = 0, rst_i = 0, start = 0, start8 = 0;
  logic [15:0] data = '0, bcd, bcd8;
  logic [7:0] data8 = '0;
  logic [3:0] lead, lead8;
  logic busy, done, ovf, busy8, done8, ovf8;
  int checks = 0, errors = 0;
  typedef struct {int v; logic [15:0] bcd; logic [3:0] lead; logic ovf;} vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  bin_to_bcd_seq #(.N(16)) dut (.clk_i(clk), .rst_i(rst_i), .start_i(start), .data_i(data),
    .bcd_o(bcd), .lead_o(lead), .busy_o(busy), .done_o(done), .ovf_o(ovf));
  bin_to_bcd_seq #(.N(8)) dut8 (.clk_i(clk), .rst_i(rst_i), .start_i(start8), .data_i(data8),
    .bcd_o(bcd8), .lead_o(lead8), .busy_o(busy8), .done_o(done8), .ovf_o(ovf8));
  task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s act=%0h exp=%0h", tag, f, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [20:0] model(input int v);
    int s, d3, d2, d1, d0;
    logic l3, l2, l1;
    s = v > 9999 ? 9999 : v;
    d3 = s / 1000; d2 = s / 100 % 10; d1 = s / 10 % 10; d0 = s % 10;
    l3 = d3 == 0; l2 = l3 && d2 == 0; l1 = l2 && d1 == 0;
    return {v > 9999, l3, l2, l1, 1'b0, 4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction
  task automatic start_conv(input int v);
    data = 16'(v);
    start = 1;
    step();
    start = 0;
  endtask
  task automatic wait_done(output int bc, output bit ok);
    bc = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1; break; end
      if (busy) bc++;
      step();
    end
  endtask
  task automatic convert(input string tag, input int v, input logic [15:0] eb, input logic [3:0] el, input logic eo);
    int bc;
    bit ok;
    start_conv(v);
    wait_done(bc, ok);
    chk(tag, "done_seen", 32'(ok), 1);
    chk(tag, "bcd", 32'(bcd), 32'(eb));
    chk(tag, "lead", 32'(lead), 32'(el));
    chk(tag, "ovf", 32'(ovf), 32'(eo));
    chk(tag, "busy_cycles", bc, 17);
    chk(tag, "busy_in_done", 32'(busy), 0);
  endtask
  initial begin
    int bc, pulses, v;
    bit ok;
    logic [20:0] m;
    vecs[0] = '{0, 16'h0000, 4'b1110, 0};
    vecs[1] = '{1234, 16'h1234, 4'b0000, 0};
    vecs[2] = '{9999, 16'h9999, 4'b0000, 0};
    vecs[3] = '{10000, 16'h9999, 4'b0000, 1};
    vecs[4] = '{65535, 16'h9999, 4'b0000, 1};
    vecs[5] = '{5, 16'h0005, 4'b1110, 0};
    vecs[6] = '{90, 16'h0090, 4'b1100, 0};
    vecs[7] = '{305, 16'h0305, 4'b1000, 0};
    repeat (3) step();
    chk("reset", "bcd", 32'(bcd), 0);
    chk("reset", "lead", 32'(lead), 32'b1110);
    chk("reset", "busy", 32'(busy), 0);
    chk("reset", "done", 32'(done), 0);
    chk("reset", "ovf", 32'(ovf), 0);
    rst_i = 1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(); pulses += int'(done); end
    chk("idle", "spurious_done", pulses, 0);
    foreach (vecs[i]) begin
      convert($sformatf("vec%0d", i), vecs[i].v, vecs[i].bcd, vecs[i].lead, vecs[i].ovf);
      step();
      chk($sformatf("vec%0d", i), "done_width", 32'(done), 0);
    end
    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      m = model(v);
      convert($sformatf("rnd%0d_%0d", i, v), v, m[15:0], m[19:16], m[20]);
    end
    start_conv(7);
    repeat (4) step();
    data = 16'd500; start = 1;
    step();
    start = 0;
    wait_done(bc, ok);
    chk("ignore", "done_seen", 32'(ok), 1);
    chk("ignore", "bcd", 32'(bcd), 32'h0007);
    chk("ignore", "lead", 32'(lead), 32'b1110);
    convert("b2b", 500, 16'h0500, 4'b1000, 0);
    start_conv(4321);
    repeat (7) step();
    #2 rst_i = 0;
    #1;
    chk("async_rst", "bcd", 32'(bcd), 0);
    chk("async_rst", "lead", 32'(lead), 32'b1110);
    chk("async_rst", "busy", 32'(busy), 0);
    chk("async_rst", "done", 32'(done), 0);
    chk("async_rst", "ovf", 32'(ovf), 0);
    repeat (2) step();
    rst_i = 1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin step(); pulses += int'(done); end
    chk("async_rst", "done_after_release", pulses, 0);
    convert("after_rst", 4321, 16'h4321, 4'b0000, 0);
    data8 = 8'd255; start8 = 1;
    step();
    start8 = 0;
    bc = 0; ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin ok = 1; break; end
      if (busy8) bc++;
      step();
    end
    chk("n8", "done_seen", 32'(ok), 1);
    chk("n8", "busy_cycles", bc, 9);
    chk("n8", "bcd", 32'(bcd8), 32'h0255);
    chk("n8", "lead", 32'(lead8), 32'b1000);
    chk("n8", "ovf", 32'(ovf8), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
